// File: rtl/taxi_ram_2rw_pipe.sv
// Dual-port (2x read/write) RAM with byte strobes and pipelined reads.
// Ports: clk/rst, a_* and b_* access ports (en, addr, wr_en, wr_data, wr_strb, rd_data, rd_valid).
module taxi_ram_2rw_pipe #(
  parameter int    ADDR_W   = 16,
  parameter int    DATA_W   = 16,
  parameter int    STRB_EN  = 1,
  parameter int    STRB_W   = DATA_W/8,
  parameter int    RD_LAT   = 1,
  parameter string RDW_MODE = "READ_FIRST"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_wr_en,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic [STRB_W-1:0] a_wr_strb,
  output logic [DATA_W-1:0] a_rd_data,
  output logic              a_rd_valid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_wr_en,
  input  logic [DATA_W-1:0] b_wr_data,
  input  logic [STRB_W-1:0] b_wr_strb,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              b_rd_valid
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int BYTE_W = (STRB_W > 0) ? DATA_W/STRB_W : DATA_W;
  localparam bit MODE_RF = (RDW_MODE == "READ_FIRST");
  localparam bit MODE_WF = (RDW_MODE == "WRITE_FIRST");
  localparam bit MODE_NC = (RDW_MODE == "NO_CHANGE");

  if (STRB_EN != 0 &&
      (STRB_W < 1 || BYTE_W * STRB_W != DATA_W)) begin : g_bad_strb
    $fatal(1, "DATA_W must be STRB_W times a byte width");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $fatal(1, "RD_LAT must be in 1..4");
  end
  if (!(MODE_RF || MODE_WF || MODE_NC)) begin : g_bad_mode
    $fatal(1, "RDW_MODE must be READ_FIRST, WRITE_FIRST or NO_CHANGE");
  end

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] a_mask, b_mask;

  if (STRB_EN != 0) begin : g_strb
    for (genvar i = 0; i < STRB_W; i++) begin : g_byte
      assign a_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{a_wr_strb[i]}};
      assign b_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{b_wr_strb[i]}};
    end
  end else begin : g_nostrb
    logic unused_strb;
    assign unused_strb = ^{a_wr_strb, b_wr_strb};
    assign a_mask = '1;
    assign b_mask = '1;
  end

  logic              a_we, b_we, a_hit;
  logic [DATA_W-1:0] a_old, b_old;
  logic [DATA_W-1:0] a_new, b_own, b_base, b_new;

  assign a_we  = a_en & a_wr_en;
  assign b_we  = b_en & b_wr_en;
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  assign a_new = (a_old & ~a_mask) | (a_wr_data & a_mask);
  assign b_own = (b_old & ~b_mask) | (b_wr_data & b_mask);

  // Same-address double write: B's bytes land on top of A's merge
  assign a_hit  = a_we & b_we & (a_addr == b_addr);
  assign b_base = a_hit ? a_new : b_old;
  assign b_new  = (b_base & ~b_mask) | (b_wr_data & b_mask);

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_new;
    if (b_we) mem[b_addr] <= b_new;
  end

  // Per-port issue: index 0 = A, 1 = B
  logic              iv [2];
  logic [DATA_W-1:0] id [2];

  always_comb begin
    iv[0] = a_en & ~(MODE_NC & a_wr_en);
    iv[1] = b_en & ~(MODE_NC & b_wr_en);
    id[0] = (MODE_WF && a_wr_en) ? a_new : a_old;
    id[1] = (MODE_WF && b_wr_en) ? b_own : b_old;
  end

  logic              pv [2][RD_LAT];
  logic [DATA_W-1:0] pd [2][RD_LAT];

  // The last stage only loads on valid so rd_data holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < RD_LAT; i++) begin
          pv[p][i] <= 1'b0;
          pd[p][i] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int i = RD_LAT-1; i > 0; i--) begin
          pv[p][i] <= pv[p][i-1];
          if (i < RD_LAT-1 || pv[p][i-1])
            pd[p][i] <= pd[p][i-1];
        end
        pv[p][0] <= iv[p];
        if (RD_LAT > 1 || iv[p])
          pd[p][0] <= id[p];
      end
    end
  end

  assign a_rd_valid = pv[0][RD_LAT-1];
  assign a_rd_data  = pd[0][RD_LAT-1];
  assign b_rd_valid = pv[1][RD_LAT-1];
  assign b_rd_data  = pd[1][RD_LAT-1];

endmodule

// File: tb/tb_taxi_ram_2rw_pipe.sv
// Bench for taxi_ram_2rw_pipe: four instances (mixed latency/mode/strobe)
// share stimulus; directed table with hand-computed values plus random run.
module tb_taxi_ram_2rw_pipe;

  localparam int CMAX = 2048;
  localparam int LAT  [4] = '{3, 1, 4, 2};
  localparam int MODE [4] = '{0, 1, 2, 0};
  localparam bit SEN  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_wr_en, b_en, b_wr_en;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_wr_data, b_wr_data;
  logic [1:0]  a_wr_strb, b_wr_strb;
  logic        av [4];
  logic        bv [4];
  logic [15:0] ard [4];
  logic [15:0] brd [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    taxi_ram_2rw_pipe #(
      .ADDR_W   (4),
      .DATA_W   (16),
      .STRB_EN  (g == 3 ? 0 : 1),
      .STRB_W   (2),
      .RD_LAT   (g == 0 ? 3 : g == 1 ? 1 : g == 2 ? 4 : 2),
      .RDW_MODE (g == 1 ? "WRITE_FIRST" :
                 g == 2 ? "NO_CHANGE" : "READ_FIRST")
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .a_en       (a_en),
      .a_addr     (a_addr),
      .a_wr_en    (a_wr_en),
      .a_wr_data  (a_wr_data),
      .a_wr_strb  (a_wr_strb),
      .a_rd_data  (ard[g]),
      .a_rd_valid (av[g]),
      .b_en       (b_en),
      .b_addr     (b_addr),
      .b_wr_en    (b_wr_en),
      .b_wr_data  (b_wr_data),
      .b_wr_strb  (b_wr_strb),
      .b_rd_data  (brd[g]),
      .b_rd_valid (bv[g])
    );
  end

  typedef struct {
    bit         rst;
    bit         ae;
    logic [3:0] aa;
    bit         aw;
    logic [15:0] ad;
    logic [1:0] as;
    bit         be;
    logic [3:0] ba;
    bit         bw;
    logic [15:0] bd;
    logic [1:0] bs;
    bit         ck;
    int         cd;
    bit         cp;
    bit         ev;
    logic [15:0] ed;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          ev   [4][2][CMAX];
  logic [15:0] ed   [4][2][CMAX];
  logic [15:0] hold [4][2];
  logic [15:0] mm   [4][16];

  function automatic vec_t nop();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic vec_t wa(vec_t v, logic [3:0] a,
                              logic [15:0] d, logic [1:0] s);
    v.ae = 1; v.aw = 1; v.aa = a; v.ad = d; v.as = s;
    return v;
  endfunction

  function automatic vec_t ra(vec_t v, logic [3:0] a);
    v.ae = 1; v.aw = 0; v.aa = a;
    return v;
  endfunction

  function automatic vec_t wb(vec_t v, logic [3:0] a,
                              logic [15:0] d, logic [1:0] s);
    v.be = 1; v.bw = 1; v.ba = a; v.bd = d; v.bs = s;
    return v;
  endfunction

  function automatic vec_t rb(vec_t v, logic [3:0] a);
    v.be = 1; v.bw = 0; v.ba = a;
    return v;
  endfunction

  function automatic vec_t rs(vec_t v);
    v.rst = 1;
    return v;
  endfunction

  function automatic vec_t ck(vec_t v, int k, bit p,
                              bit e, logic [15:0] d);
    v.ck = 1; v.cd = k; v.cp = p; v.ev = e; v.ed = d;
    return v;
  endfunction

  function automatic logic [15:0] mg(logic [15:0] o, logic [15:0] d,
                                     logic [1:0] s, bit sen);
    logic [15:0] r;
    r = o;
    for (int i = 0; i < 2; i++)
      if (!sen || s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic step(input vec_t v);
    logic        va;
    logic [15:0] da;
    bit          en [2];
    bit          wr [2];
    logic [3:0]  ad [2];
    logic [15:0] dt [2];
    logic [1:0]  sb [2];
    logic [15:0] old, own;
    int          t;

    rst = v.rst;
    a_en = v.ae; a_addr = v.aa; a_wr_en = v.aw;
    a_wr_data = v.ad; a_wr_strb = v.as;
    b_en = v.be; b_addr = v.ba; b_wr_en = v.bw;
    b_wr_data = v.bd; b_wr_strb = v.bs;

    if (cyc >= 1) begin
      for (int k = 0; k < 4; k++) begin
        for (int p = 0; p < 2; p++) begin
          va = p ? bv[k] : av[k];
          da = p ? brd[k] : ard[k];
          if (ev[k][p][cyc]) hold[k][p] = ed[k][p][cyc];
          checks++;
          if (va !== ev[k][p][cyc] || da !== hold[k][p]) begin
            errors++;
            $display("FAIL model dut%0d port%0d cyc%0d: got v=%0b d=%h, want v=%0b d=%h",
                     k, p, cyc, va, da, ev[k][p][cyc], hold[k][p]);
          end
        end
      end
    end

    if (v.ck) begin
      va = v.cp ? bv[v.cd] : av[v.cd];
      da = v.cp ? brd[v.cd] : ard[v.cd];
      checks++;
      if (va !== v.ev || da !== v.ed) begin
        errors++;
        $display("FAIL table dut%0d port%0d cyc%0d: got v=%0b d=%h, want v=%0b d=%h",
                 v.cd, v.cp, cyc, va, da, v.ev, v.ed);
      end
    end

    en[0] = v.ae; wr[0] = v.aw; ad[0] = v.aa; dt[0] = v.ad; sb[0] = v.as;
    en[1] = v.be; wr[1] = v.bw; ad[1] = v.ba; dt[1] = v.bd; sb[1] = v.bs;

    for (int k = 0; k < 4; k++) begin
      if (v.rst) begin
        for (int p = 0; p < 2; p++) begin
          for (int c = cyc + 1; c < CMAX; c++) ev[k][p][c] = 0;
          hold[k][p] = '0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        old = mm[k][ad[p]];
        own = mg(old, dt[p], sb[p], SEN[k]);
        if (!v.rst && en[p] && !(MODE[k] == 2 && wr[p])) begin
          t = cyc + LAT[k];
          ev[k][p][t] = 1;
          ed[k][p][t] = (MODE[k] == 1 && wr[p]) ? own : old;
        end
      end
      // Writes applied A then B, so B wins any byte both strobe
      for (int p = 0; p < 2; p++)
        if (en[p] && wr[p])
          mm[k][ad[p]] = mg(mm[k][ad[p]], dt[p], sb[p], SEN[k]);
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  vec_t tbl [39];
  vec_t rv;

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) mm[k][i] = '0;
      hold[k][0] = '0;
      hold[k][1] = '0;
    end

    tbl[0]  = wa(nop(), 5, 16'h1234, 2'b11);
    tbl[1]  = ck(nop(), 1, 0, 1, 16'h1234);
    tbl[2]  = ra(nop(), 5);
    tbl[3]  = ck(nop(), 0, 0, 1, 16'h0000);
    tbl[4]  = ck(nop(), 0, 0, 0, 16'h0000);
    tbl[5]  = ck(nop(), 0, 0, 1, 16'h1234);
    tbl[6]  = ck(nop(), 0, 0, 0, 16'h1234);
    tbl[7]  = wa(nop(), 7, 16'hAAAA, 2'b11);
    tbl[8]  = wa(nop(), 7, 16'h5555, 2'b01);
    tbl[9]  = ra(nop(), 7);
    tbl[10] = ck(nop(), 1, 0, 1, 16'hAA55);
    tbl[11] = wa(nop(), 3, 16'h0001, 2'b11);
    tbl[12] = ck(wa(nop(), 3, 16'h00FF, 2'b11), 0, 0, 1, 16'hAA55);
    tbl[13] = ck(nop(), 1, 0, 1, 16'h00FF);
    tbl[14] = ck(nop(), 2, 0, 0, 16'hAA55);
    tbl[15] = ck(nop(), 0, 0, 1, 16'h0001);
    tbl[16] = ck(nop(), 2, 0, 0, 16'hAA55);
    tbl[17] = wb(wa(nop(), 9, 16'h1111, 2'b11), 9, 16'h2222, 2'b11);
    tbl[18] = ra(nop(), 9);
    tbl[19] = wb(wa(nop(), 9, 16'h1111, 2'b11), 9, 16'h2222, 2'b10);
    tbl[20] = rb(nop(), 9);
    tbl[21] = ck(nop(), 0, 0, 1, 16'h2222);
    tbl[22] = wa(nop(), 4, 16'h0ABC, 2'b11);
    tbl[23] = ck(wb(ra(nop(), 4), 4, 16'h0DEF, 2'b11), 0, 1, 1, 16'h2211);
    tbl[24] = ra(nop(), 4);
    tbl[25] = nop();
    tbl[26] = ck(nop(), 0, 0, 1, 16'h0ABC);
    tbl[27] = ck(nop(), 0, 0, 1, 16'h0DEF);
    tbl[28] = ra(nop(), 4);
    tbl[29] = rs(wb(nop(), 11, 16'h7777, 2'b11));
    tbl[30] = ck(rb(nop(), 4), 2, 0, 0, 16'h0000);
    tbl[31] = ck(nop(), 1, 1, 1, 16'h0DEF);
    tbl[32] = ck(nop(), 2, 0, 0, 16'h0000);
    tbl[33] = ck(nop(), 2, 0, 0, 16'h0000);
    tbl[34] = ck(ra(nop(), 11), 2, 1, 1, 16'h0DEF);
    tbl[35] = ck(nop(), 1, 0, 1, 16'h7777);
    tbl[36] = wa(nop(), 5, 16'hFFFF, 2'b00);
    tbl[37] = ck(ra(nop(), 5), 1, 0, 1, 16'h1234);
    tbl[38] = ck(nop(), 1, 0, 1, 16'h1234);

    rst = 1'b1;
    a_en = 0; a_addr = '0; a_wr_en = 0; a_wr_data = '0; a_wr_strb = '0;
    b_en = 0; b_addr = '0; b_wr_en = 0; b_wr_data = '0; b_wr_strb = '0;
    @(negedge clk);

    step(rs(nop()));
    step(rs(nop()));
    step(nop());

    for (int i = 0; i < 39; i++) step(tbl[i]);

    for (int n = 0; n < 1500; n++) begin
      rv = nop();
      rv.rst = ($urandom_range(0, 63) == 0);
      rv.ae  = ($urandom_range(0, 3) != 0);
      rv.aa  = 4'($urandom_range(0, 15));
      rv.aw  = 1'($urandom_range(0, 1));
      rv.ad  = 16'($urandom);
      rv.as  = 2'($urandom_range(0, 3));
      rv.be  = ($urandom_range(0, 3) != 0);
      rv.ba  = 4'($urandom_range(0, 15));
      rv.bw  = 1'($urandom_range(0, 1));
      rv.bd  = 16'($urandom);
      rv.bs  = 2'($urandom_range(0, 3));
      step(rv);
    end

    for (int n = 0; n < 6; n++) step(nop());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_ram_2rw_pipe.md
TAXI_RAM_2RW_PIPE -- requirements
Module: taxi_ram_2rw_pipe

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16, meaning the address width; depth is 2**ADDR_W words.
REQ-002 The block SHALL take parameter DATA_W, default 16, meaning the word width.
REQ-003 The block SHALL take parameter STRB_EN, default 1, meaning byte strobes are honoured; when 0, writes update the full word.
REQ-004 The block SHALL take parameter STRB_W, default DATA_W/8, meaning the strobe width.
REQ-005 The block SHALL take parameter RD_LAT, default 1, legal range 1..4, meaning the read latency in cycles.
REQ-006 The block SHALL take parameter RDW_MODE, default "READ_FIRST", legal values "READ_FIRST", "WRITE_FIRST", "NO_CHANGE", meaning same-port read-during-write behaviour.
REQ-007 The block SHALL have port clk, input, 1 bit, meaning the single clock for both ports.
REQ-008 The block SHALL have port rst, input, 1 bit, meaning reset; rst is synchronous and active-high.
REQ-009 The block SHALL have ports a_en / b_en, input, 1 bit, meaning port access enable.
REQ-010 The block SHALL have ports a_addr / b_addr, input, ADDR_W bits, meaning the word address.
REQ-011 The block SHALL have ports a_wr_en / b_wr_en, input, 1 bit, meaning write (1) or read (0) when enabled.
REQ-012 The block SHALL have ports a_wr_data / b_wr_data, input, DATA_W bits, meaning write data.
REQ-013 The block SHALL have ports a_wr_strb / b_wr_strb, input, STRB_W bits, meaning per-byte write enables.
REQ-014 The block SHALL have ports a_rd_data / b_rd_data, output, DATA_W bits, meaning read data.
REQ-015 The block SHALL have ports a_rd_valid / b_rd_valid, output, 1 bit, meaning a_rd_data / b_rd_data is new this cycle.
REQ-016 Elaboration SHALL fail with $fatal if STRB_EN=1 and DATA_W is not STRB_W times an integer byte width, if RD_LAT is outside 1..4, or if RDW_MODE is not a legal value.

Function
REQ-017 The memory SHALL power up with every word at zero; rst SHALL NOT alter memory contents.
REQ-018 A read issued in cycle N (en=1, wr_en=0) SHALL assert rd_valid in exactly cycle N+RD_LAT, with rd_data equal to the word at issue time.
REQ-019 The read pipeline SHALL never stall and SHALL accept one access per port per cycle, with no bubbles.
REQ-020 rd_data SHALL change only in cycles where rd_valid=1 and SHALL otherwise hold its last value.
REQ-021 A write SHALL update the strobed bytes, or the full word when STRB_EN=0, at the end of its issue cycle.
REQ-022 A write with all strobes 0 SHALL leave memory unchanged but SHALL still follow the RDW_MODE output rule.
REQ-023 For a write in READ_FIRST mode, rd_valid SHALL assert after RD_LAT cycles, with rd_data equal to the pre-write word.
REQ-024 For a write in WRITE_FIRST mode, rd_valid SHALL assert after RD_LAT cycles, with rd_data equal to the post-write word (strobe-merged).
REQ-025 For a write in NO_CHANGE mode, the write SHALL produce no rd_valid, and rd_data SHALL hold.
REQ-026 When both ports write the same address in the same cycle, each byte strobed by port B SHALL take B's data; bytes strobed only by A SHALL take A's data.
REQ-027 When one port reads an address the other port writes in the same cycle, the read SHALL return the pre-write word.
REQ-028 Ports A and B SHALL be fully independent except for the collision rules in REQ-026 and REQ-027.
REQ-029 Address wrap SHALL be implicit: all 2**ADDR_W addresses are valid, and no out-of-range condition exists.

Reset
REQ-030 While rst=1, both rd_valid outputs SHALL be 0 and both rd_data outputs SHALL be zero from the cycle after rst is sampled high.
REQ-031 rst SHALL clear all in-flight pipeline stages, so reads issued before or during rst never produce rd_valid.
REQ-032 Writes presented while rst=1 SHALL still update memory.
REQ-033 The first access issued in the cycle after rst deasserts SHALL follow normal latency.

Verification
REQ-034 Read latency, RD_LAT=3: write 0x1234 at A addr 5, then read A addr 5 in cycle 10 -> a_rd_valid=1 only in cycle 13, a_rd_data=0x1234, and held afterwards.
REQ-035 Byte strobes: word 0xAAAA at addr 7, write 0x5555 with strb=2'b01 -> later read returns 0xAA55.
REQ-036 RDW modes: addr 3 holds 0x0001, same-port write 0x00FF -> READ_FIRST returns 0x0001; WRITE_FIRST returns 0x00FF; NO_CHANGE gives no rd_valid.
REQ-037 Collision: A writes 0x1111 and B writes 0x2222 to addr 9 in the same cycle, both strb=2'b11 -> addr 9 holds 0x2222; with B strb=2'b10 -> addr 9 holds 0x2211.
REQ-038 Cross-port: addr 4 holds 0x0ABC; A reads addr 4 while B writes 0x0DEF -> A returns 0x0ABC and a subsequent read returns 0x0DEF.
REQ-039 Reset mid-flight, RD_LAT=4: read issued, rst pulsed 1 cycle later -> no rd_valid ever appears, and rd_data=0.
